// File: rtl/dmem_lsu_pkg.sv
// ---------------------------------------------------------------------------
// dmem_lsu_pkg
//   Shared definitions for the data-memory load/store unit.
//   - SZ_* : request size encodings (byte / halfword / word / illegal).
//   - lsu_state_t : FSM state encoding of the unit.
//   - lsu_req_t : request fields captured at the accept edge.
//   - MEM_WORDS_DEFAULT : default depth of the attached word memory.
// ---------------------------------------------------------------------------
package dmem_lsu_pkg;

  localparam int MEM_WORDS_DEFAULT = 64;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } lsu_state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/dmem_lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
//   Purely combinational big-endian lane steering for the load/store unit.
//   Byte k (k = byte_off) lives in word[31-8k -: 8]; the halfword with
//   byte_off[1] = 0 lives in word[31:16], with byte_off[1] = 1 in word[15:0].
//
//   Ports
//     byte_off    in  2   low address bits of the access
//     size        in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//     is_unsigned in  1   zero-extend (1) or sign-extend (0) sub-word loads
//     word        in  32  word read from memory
//     wdata       in  32  right-justified store data
//     load_data   out 32  extracted and extended load result
//     store_word  out 32  word with the addressed lane replaced by wdata
// ---------------------------------------------------------------------------
module lsu_lane_align
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]  byte_off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Load path: pick the lane, then extend.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on entry so
    // that no path through the case statements can leave it unassigned,
    // which would otherwise infer a latch.
    lane_b    = 8'h00;
    lane_h    = 16'h0000;
    load_data = word;

    case (byte_off)
      2'd0: lane_b = word[31:24];
      2'd1: lane_b = word[23:16];
      2'd2: lane_b = word[15:8];
      2'd3: lane_b = word[7:0];
      default: lane_b = 8'h00;
    endcase

    lane_h = byte_off[1] ? word[15:0] : word[31:16];

    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
      SZ_HALF: load_data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
      default: load_data = word;
    endcase
  end

  // Store path: read-modify-write merge, untouched lanes pass through.
  always_comb begin
    store_word = word;
    case (size)
      SZ_BYTE: begin
        case (byte_off)
          2'd0: store_word[31:24] = wdata[7:0];
          2'd1: store_word[23:16] = wdata[7:0];
          2'd2: store_word[15:8]  = wdata[7:0];
          2'd3: store_word[7:0]   = wdata[7:0];
          default: store_word = word;
        endcase
      end
      SZ_HALF: begin
        if (byte_off[1]) store_word[15:0]  = wdata[15:0];
        else             store_word[31:16] = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// ---------------------------------------------------------------------------
// dmem_lsu
//   Multi-cycle load/store unit between the core's MEM stage and a
//   word-only data memory. Sub-word stores are done as read-modify-write.
//
//   Latency from the accept edge (edge 0) to the response cycle:
//     error -> RESP                        (rsp in cycle after edge 0)
//     load / word store -> READ|WRITE -> RESP
//     sub-word store -> READ -> WRITE -> RESP
//
//   Ports
//     clk           in  1   rising-edge clock shared with the memory
//     reset         in  1   asynchronous, active-high
//     req_valid     in  1   core presents a request
//     req_ready     out 1   unit idle, request accepted at the next edge
//     req_we        in  1   1 = store, 0 = load
//     req_size      in  2   SZ_BYTE / SZ_HALF / SZ_WORD / SZ_ILL
//     req_unsigned  in  1   zero-extend sub-word loads
//     req_addr      in  32  byte address
//     req_wdata     in  32  right-justified store data
//     rsp_valid     out 1   one-cycle response pulse
//     rsp_rdata     out 32  extended load data, 0 for stores and errors
//     rsp_err       out 1   misaligned / illegal size / out of range
//     mem_we        out 1   memory write enable, high only in WRITE
//     mem_a         out 32  word-aligned memory address
//     mem_wd        out 32  memory write data
//     mem_rd        in  32  combinational read data of word mem_a
// ---------------------------------------------------------------------------
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

  lsu_state_t  state, state_next;
  lsu_req_t    req_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] wd_q;

  logic        accept;
  logic        req_err;
  logic        misaligned;
  logic        out_of_range;
  logic [31:0] load_data;
  logic [31:0] store_word;

  // -------------------------------------------------------------------------
  // Error check on the live request fields; only used at the accept edge.
  // -------------------------------------------------------------------------
  always_comb begin
    misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    out_of_range = ({2'b00, req_addr[31:2]} >= MEM_WORDS_L);
    req_err      = (req_size == SZ_ILL) || misaligned || out_of_range;
  end

  assign accept = req_valid && req_ready;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, independent of
    // process evaluation order.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // -------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_we     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                  state_next = ST_RESP;
          else if (!req_we)             state_next = ST_READ;
          else if (req_size == SZ_WORD) state_next = ST_WRITE;
          else                          state_next = ST_READ;
        end
      end
      ST_READ: begin
        // Only loads and sub-word stores reach READ.
        state_next = req_q.we ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        // Decoded from the state register, so it drops as soon as reset
        // forces the state back to IDLE.
        mem_we     = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Request / response registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wd_q    <= '0;
    end else if (accept) begin
      req_q   <= '{we:          req_we,
                   size:        req_size,
                   is_unsigned: req_unsigned,
                   addr:        req_addr,
                   wdata:       req_wdata};
      err_q   <= req_err;
      // Stores and errors respond with zero data.
      rdata_q <= '0;
      // A word store writes straight from the request; a sub-word store
      // overwrites this with the merged word at the end of READ.
      wd_q    <= req_we ? req_wdata : '0;
    end else if (state == ST_READ) begin
      if (req_q.we) wd_q    <= store_word;
      else          rdata_q <= load_data;
    end
  end

  // -------------------------------------------------------------------------
  // Lane extract / merge on the word currently being read
  // -------------------------------------------------------------------------
  lsu_lane_align u_lane_align (
    .byte_off    (req_q.addr[1:0]),
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .word        (mem_rd),
    .wdata       (req_q.wdata),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  assign mem_a     = {req_q.addr[31:2], 2'b00};
  assign mem_wd    = wd_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// ---------------------------------------------------------------------------
// tb_dmem_lsu
//   Self-checking bench for dmem_lsu. Provides a word memory on the dmem
//   port, a behavioural reference model of the unit (arithmetic on a shadow
//   memory), a table of directed vectors, hand-written sequences for
//   back-to-back requests and reset during WRITE, and randomized requests.
// ---------------------------------------------------------------------------
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  localparam int WORDS = 64;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;    // response cycle number, 1 = cycle after accept edge
    logic        wr;
    int          idx;
    logic [31:0] word;   // word at idx after the request
  } exp_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          rsp_cyc;
    int          valid_cnt;
    int          we_cyc;
    int          we_cnt;
    int          bad_align;
  } obs_t;

  typedef struct {
    logic        pre;
    logic [31:0] pre_word;
    req_t        r;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_cyc;
    logic [31:0] exp_word;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, mem_we;
  logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.MEM_WORDS(WORDS)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_a        (mem_a),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd)
  );

  // ---------------- attached word memory (dmem) ----------------
  logic [31:0] mem [WORDS];
  logic [31:0] ref_mem [WORDS];
  logic        bd_en;
  logic [5:0]  bd_idx;
  logic [31:0] bd_dat;

  assign mem_rd = (mem_a[31:2] < WORDS) ? mem[mem_a[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (bd_en) mem[bd_idx] <= bd_dat;
    else if (mem_we && (mem_a[31:2] < WORDS)) mem[mem_a[7:2]] <= mem_wd;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    bd_en  = 1'b1;
    bd_idx = 6'(idx);
    bd_dat = d;
    @(posedge clk);
    #1 bd_en = 1'b0;
    ref_mem[idx] = d;
  endtask

  // Reference model: error rules, big-endian lanes and latencies computed
  // with plain shifts and masks on the shadow memory.
  function automatic exp_t model(input req_t r);
    exp_t        e;
    logic [31:0] w, v, mask, widx;
    int          off, sh;
    widx    = r.addr >> 2;
    off     = int'(r.addr & 32'd3);
    e.err   = (r.size == 2'd3) || (r.size == 2'd1 && (off % 2) != 0) ||
              (r.size == 2'd2 && off != 0) || (widx >= WORDS);
    e.rdata = 32'h0;
    e.wr    = 1'b0;
    e.idx   = 0;
    e.word  = 32'h0;
    e.cyc   = 1;
    if (e.err) return e;
    e.idx  = int'(widx);
    w      = ref_mem[e.idx];
    e.word = w;
    sh     = (r.size == 2'd0) ? 8 * (3 - off) : 16 * (1 - off / 2);
    mask   = (r.size == 2'd0) ? 32'hFF : 32'hFFFF;
    if (!r.we) begin
      e.cyc = 2;
      if (r.size == 2'd2) v = w;
      else begin
        v = (w >> sh) & mask;
        if (!r.uns && ((v & ((mask >> 1) + 32'd1)) != 0)) v = v | ~mask;
      end
      e.rdata = v;
    end else begin
      e.wr = 1'b1;
      if (r.size == 2'd2) begin
        e.word = r.wdata;
        e.cyc  = 2;
      end else begin
        e.word = (w & ~(mask << sh)) | ((r.wdata & mask) << sh);
        e.cyc  = 3;
      end
      ref_mem[e.idx] = e.word;
    end
    return e;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   s, idx, low;
    r.we   = 1'($urandom_range(0, 1));
    s      = int'($urandom_range(0, 9));
    r.size = (s < 3) ? 2'd0 : (s < 6) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3;
    r.uns  = 1'($urandom_range(0, 1));
    idx    = ($urandom_range(0, 15) == 0) ? int'($urandom_range(64, 1000))
                                          : int'($urandom_range(0, 63));
    low    = int'($urandom_range(0, 3));
    if ($urandom_range(0, 3) != 0) begin
      if (r.size == 2'd1)      low = low & 2;
      else if (r.size == 2'd2) low = 0;
    end
    r.addr  = 32'(idx * 4 + low);
    r.wdata = $urandom;
    return r;
  endfunction

  function automatic vec_t mk(input logic pre, input logic [31:0] pw, input logic we,
                              input logic [1:0] sz, input logic uns, input logic [31:0] a,
                              input logic [31:0] wd, input logic ee, input logic [31:0] er,
                              input int ec, input logic [31:0] ew);
    vec_t v;
    v.pre = pre; v.pre_word = pw;
    v.r.we = we; v.r.size = sz; v.r.uns = uns; v.r.addr = a; v.r.wdata = wd;
    v.exp_err = ee; v.exp_rdata = er; v.exp_cyc = ec; v.exp_word = ew;
    return v;
  endfunction

  task automatic drive(input req_t r);
    req_we       = r.we;
    req_size     = r.size;
    req_unsigned = r.uns;
    req_addr     = r.addr;
    req_wdata    = r.wdata;
  endtask

  // One isolated request from idle; records what the DUT does over the
  // next six cycles. Fields are scrambled right after accept.
  task automatic run_req(input req_t r, output obs_t o);
    o.err = 1'b0; o.rdata = 32'h0; o.rsp_cyc = -1; o.valid_cnt = 0;
    o.we_cyc = -1; o.we_cnt = 0; o.bad_align = 0;
    @(negedge clk);
    check("ready_before_req", req_ready, 1'b1);
    drive(r);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (rsp_valid) begin
        o.valid_cnt++;
        if (o.rsp_cyc < 0) begin
          o.rsp_cyc = j;
          o.err     = rsp_err;
          o.rdata   = rsp_rdata;
        end
      end
      if (mem_we) begin
        o.we_cnt++;
        if (o.we_cyc < 0) o.we_cyc = j;
        if (mem_a[1:0] != 2'b00) o.bad_align++;
      end
    end
  endtask

  task automatic check_obs(input string tag, input obs_t o, input logic ee,
                           input logic [31:0] er, input int ec, input logic ewr);
    check({tag, "_err"}, o.err, ee);
    check({tag, "_rdata"}, o.rdata, er);
    check({tag, "_rsp_cycle"}, 32'(o.rsp_cyc), 32'(ec));
    check({tag, "_rsp_pulses"}, 32'(o.valid_cnt), 32'd1);
    check({tag, "_we_pulses"}, 32'(o.we_cnt), ewr ? 32'd1 : 32'd0);
    if (ewr) check({tag, "_we_cycle"}, 32'(o.we_cyc), 32'(ec - 1));
    check({tag, "_we_align"}, 32'(o.bad_align), 32'd0);
  endtask

  // Requests presented back to back with req_valid held high.
  task automatic back_to_back(input int n);
    req_t        q[$];
    exp_t        eq[$];
    int          acc_cyc[$];
    logic [32:0] got[$];
    exp_t        e;
    int          i, cyc, nrsp;
    logic        acc;
    i = 0; cyc = 0; nrsp = 0;
    for (int k = 0; k < n; k++) q.push_back(rand_req());
    @(negedge clk);
    drive(q[0]);
    req_valid = 1'b1;
    while (nrsp < n && cyc < 200) begin
      if (rsp_valid) begin
        got.push_back({rsp_err, rsp_rdata});
        nrsp++;
      end
      acc = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        e = model(q[i]);
        eq.push_back(e);
        acc_cyc.push_back(cyc);
        i++;
        if (i < n) drive(q[i]);
        else       req_valid = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_accepts", 32'(i), 32'(n));
    check("b2b_responses", 32'(nrsp), 32'(n));
    for (int k = 0; k < nrsp && k < eq.size(); k++) begin
      check($sformatf("b2b%0d_err", k), {31'h0, got[k][32]}, {31'h0, eq[k].err});
      check($sformatf("b2b%0d_rdata", k), got[k][31:0], eq[k].rdata);
    end
    for (int k = 0; k + 1 < acc_cyc.size(); k++)
      check($sformatf("b2b%0d_spacing", k), 32'(acc_cyc[k+1] - acc_cyc[k]), 32'(eq[k].cyc + 1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs[16];
    obs_t o;
    exp_t e;
    req_t r;
    logic seen;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    bd_en = 1'b0; bd_idx = 6'h0; bd_dat = 32'h0;

    repeat (2) @(negedge clk);
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_err", rsp_err, 1'b0);
    check("reset_mem_we", mem_we, 1'b0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_mem_a", mem_a, 32'h0);
    check("reset_mem_wd", mem_wd, 32'h0);

    for (int i = 0; i < WORDS; i++) preload(i, $urandom);
    @(negedge clk);
    reset = 1'b0;

    // pre, preword, we, size, uns, addr, wdata, err, rdata, cyc, word after
    vecs[0]  = mk(1, 32'h0,        1, 2'd2, 0, 32'h10,  32'hDEADBEEF, 0, 32'h0,        2, 32'hDEADBEEF);
    vecs[1]  = mk(0, 32'h0,        0, 2'd2, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 2, 32'hDEADBEEF);
    vecs[2]  = mk(1, 32'h11223344, 1, 2'd0, 0, 32'h11,  32'h123456AB, 0, 32'h0,        3, 32'h11AB3344);
    vecs[3]  = mk(1, 32'h80FF7F01, 0, 2'd0, 0, 32'h21,  32'h0,        0, 32'hFFFFFFFF, 2, 32'h80FF7F01);
    vecs[4]  = mk(0, 32'h0,        0, 2'd0, 1, 32'h21,  32'h0,        0, 32'h000000FF, 2, 32'h80FF7F01);
    vecs[5]  = mk(0, 32'h0,        0, 2'd1, 0, 32'h20,  32'h0,        0, 32'hFFFF80FF, 2, 32'h80FF7F01);
    vecs[6]  = mk(0, 32'h0,        0, 2'd1, 1, 32'h22,  32'h0,        0, 32'h00007F01, 2, 32'h80FF7F01);
    vecs[7]  = mk(0, 32'h0,        0, 2'd0, 0, 32'h23,  32'h0,        0, 32'h00000001, 2, 32'h80FF7F01);
    vecs[8]  = mk(0, 32'h0,        0, 2'd2, 0, 32'h02,  32'h0,        1, 32'h0,        1, 32'h0);
    vecs[9]  = mk(0, 32'h0,        1, 2'd1, 0, 32'h03,  32'hFFFF,     1, 32'h0,        1, 32'h0);
    vecs[10] = mk(0, 32'h0,        0, 2'd3, 0, 32'h04,  32'h0,        1, 32'h0,        1, 32'h0);
    vecs[11] = mk(0, 32'h0,        0, 2'd2, 0, 32'h100, 32'h0,        1, 32'h0,        1, 32'h0);
    vecs[12] = mk(0, 32'h0,        1, 2'd0, 0, 32'h103, 32'h55,       1, 32'h0,        1, 32'h0);
    vecs[13] = mk(1, 32'h11223344, 1, 2'd1, 0, 32'h12,  32'hFFFFCAFE, 0, 32'h0,        3, 32'h1122CAFE);
    vecs[14] = mk(1, 32'h55AA00FF, 0, 2'd2, 0, 32'hFC,  32'h0,        0, 32'h55AA00FF, 2, 32'h55AA00FF);
    vecs[15] = mk(0, 32'h0,        1, 2'd2, 0, 32'hFC,  32'h0BADF00D, 0, 32'h0,        2, 32'h0BADF00D);

    for (int k = 0; k < 16; k++) begin
      if (vecs[k].pre) preload(int'(vecs[k].r.addr >> 2), vecs[k].pre_word);
      e = model(vecs[k].r);
      run_req(vecs[k].r, o);
      check_obs($sformatf("vec%0d", k), o, vecs[k].exp_err, vecs[k].exp_rdata,
                vecs[k].exp_cyc, vecs[k].r.we && !vecs[k].exp_err);
      if (!vecs[k].exp_err)
        check($sformatf("vec%0d_mem", k), mem[vecs[k].r.addr[7:2]], vecs[k].exp_word);
    end

    // Reset asserted during WRITE of a sub-word store, before the edge
    // that would commit it.
    preload(12, 32'hA5A5A5A5);
    r.we = 1'b1; r.size = 2'd0; r.uns = 1'b0; r.addr = 32'h31; r.wdata = 32'h3C;
    @(negedge clk);
    drive(r);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstw_we_before", mem_we, 1'b1);
    reset = 1'b1;
    #1;
    check("rstw_we_async_drop", mem_we, 1'b0);
    check("rstw_ready_in_reset", req_ready, 1'b1);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("rstw_no_rsp", seen, 1'b0);
    check("rstw_mem_kept", mem[12], 32'hA5A5A5A5);
    check("rstw_ready_after", req_ready, 1'b1);
    r.we = 1'b0; r.uns = 1'b1;
    e = model(r);
    run_req(r, o);
    check_obs("rstw_reload", o, e.err, e.rdata, e.cyc, 1'b0);

    back_to_back(12);

    for (int k = 0; k < 150; k++) begin
      r = rand_req();
      e = model(r);
      run_req(r, o);
      check_obs($sformatf("rnd%0d", k), o, e.err, e.rdata, e.cyc, e.wr);
      if (e.wr) check($sformatf("rnd%0d_mem", k), mem[e.idx], e.word);
    end

    for (int i = 0; i < WORDS; i++)
      check($sformatf("mem_final_%0d", i), mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
